// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side data bus: FSM states,
// default geometry and the error-cause encoding used by bus checkers.
package mem_bus_pkg;

   localparam int DEFAULT_ADDR_W = 8;
   localparam int DEFAULT_DATA_W = 32;

   // Bit positions inside an error-cause vector
   localparam int ERR_ALIGN = 0;
   localparam int ERR_RANGE = 1;
   localparam int ERR_BOTH  = 2;
   localparam int ERR_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Classifies a request: byte address must be word aligned, every bit above
   // the word index must be zero, and read/write must not both be requested.
   function automatic logic [ERR_W-1:0] err_cause(
      input logic [31:0] addr,
      input logic        rd,
      input logic        wd,
      input int          addr_w
   );
      logic [ERR_W-1:0] cause;
      cause            = '0;
      cause[ERR_ALIGN] = |addr[1:0];
      cause[ERR_RANGE] = (addr >> (addr_w + 2)) != 32'd0;
      cause[ERR_BOTH]  = rd & wd;
      return cause;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM with a registered, enable-gated read port.
// No reset: contents and read register survive a bus reset.
module mem_word_array
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   // Write commit and read capture; rdata only moves when a read is enabled
   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end
      if (re) begin
         rdata <= mem[index];
      end
   end

endmodule

// File: rtl/mem_wait_responder.sv
// Stalling data-memory responder for the MIPS core: accepts one request,
// waits LATENCY cycles, then strobes mem_ready (and mem_error on a bad access).
module mem_wait_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int LATENCY = 2,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       memDir,
   input  logic [DATA_W-1:0] memDato,
   input  logic              mem_rd,
   input  logic              mem_wd,
   output logic [DATA_W-1:0] memOutput,
   output logic              mem_ready,
   output logic              mem_error,
   output logic              busy
);

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [31:0]       lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic              lat_rd;
   logic              lat_wd;
   logic              out_valid;

   logic              accept;
   logic              enter_resp;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic              acc_rd;
   logic              acc_wd;
   logic [ERR_W-1:0]  acc_err;
   logic              acc_bad;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_index;
   logic [DATA_W-1:0] ram_rdata;

   // Pick the request the array sees on the edge entering RESP: live bus
   // inputs when a zero-latency request is accepted in IDLE, otherwise the
   // latched copy, so bus activity during WAIT cannot disturb the access.
   always_comb begin
      accept = (state == IDLE) && (mem_rd || mem_wd);
      if (state == IDLE) begin
         acc_addr = memDir;
         acc_data = memDato;
         acc_rd   = mem_rd;
         acc_wd   = mem_wd;
      end else begin
         acc_addr = lat_addr;
         acc_data = lat_data;
         acc_rd   = lat_rd;
         acc_wd   = lat_wd;
      end
      acc_err    = err_cause(acc_addr, acc_rd, acc_wd, ADDR_W);
      acc_bad    = |acc_err;
      enter_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (wait_cnt == 4'd0));
      ram_we     = enter_resp && acc_wd && !acc_bad;
      ram_re     = enter_resp && acc_rd && !acc_bad;
      ram_index  = acc_addr[ADDR_W+1:2];
   end

   mem_word_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .index (ram_index),
      .wdata (acc_data),
      .rdata (ram_rdata)
   );

   // The RAM read register holds the last successful read; out_valid masks
   // it to zero after reset until a read has actually completed.
   assign memOutput = out_valid ? ram_rdata : '0;

   // Request FSM: latch in IDLE, count down in WAIT, one-cycle strobe in RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_rd    <= 1'b0;
         lat_wd    <= 1'b0;
         mem_ready <= 1'b0;
         mem_error <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_addr <= memDir;
                  lat_data <= memDato;
                  lat_rd   <= mem_rd;
                  lat_wd   <= mem_wd;
                  busy     <= 1'b1;
                  if (LATENCY == 0) begin
                     state     <= RESP;
                     mem_ready <= 1'b1;
                     mem_error <= acc_bad;
                     if (ram_re) begin
                        out_valid <= 1'b1;
                     end
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= 4'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
                  mem_error <= acc_bad;
                  if (ram_re) begin
                     out_valid <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               mem_ready <= 1'b0;
               mem_error <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
